// File: rtl/modn_counter_pkg.sv
// Shared constants for the modulo-N counter family (UART baud and bit counters).
package modn_counter_pkg;

  // OneShot input encoding.
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Default geometry used by the baud and bit counters.
  localparam int MODN_WIDTH       = 4;
  localparam int MODN_DEFAULT_MOD = 10;

endpackage

// File: rtl/modn_counter_if.sv
// Bundles the counter's control inputs and status outputs for a driving agent.
// master drives the controls and observes status; slave is the counter side.
interface modn_counter_if #(
  parameter int WIDTH = 4
);

  logic             increment;
  logic             clear;
  logic             mod_load;
  logic [WIDTH-1:0] mod_value;
  logic             one_shot;
  logic [WIDTH-1:0] count;
  logic             term_pulse;
  logic             done;
  logic             overrun;

  modport master (
    output increment, clear, mod_load, mod_value, one_shot,
    input  count, term_pulse, done, overrun
  );

  modport slave (
    input  increment, clear, mod_load, mod_value, one_shot,
    output count, term_pulse, done, overrun
  );

endinterface

// File: rtl/modn_counter.sv
// Modulo-N counter with loadable modulus, wrap/one-shot modes and sticky flags.
// Increment is a single-cycle qualifier: every cycle it is high at a rising edge
// is one accepted increment; there is no back-pressure.
module modn_counter
  import modn_counter_pkg::*;
#(
  parameter int WIDTH       = MODN_WIDTH,
  parameter int DEFAULT_MOD = MODN_DEFAULT_MOD
) (
  input  logic             SystemClock,
  input  logic             ResetCounter,
  input  logic             Increment,
  input  logic             Clear,
  input  logic             ModLoad,
  input  logic [WIDTH-1:0] ModValue,
  input  logic             OneShot,
  output logic [WIDTH-1:0] Count,
  output logic             TermPulse,
  output logic             Done,
  output logic             Overrun
);

  logic [WIDTH-1:0] mod_q;
  logic [WIDTH-1:0] term_value;
  logic [WIDTH-1:0] count_next;
  logic             one_shot_mode;
  logic             locked;
  logic             terminal;
  logic             pulse_next;
  logic             overrun_hit;

  // Terminal detection and next count; uses the registered modulus so a
  // same-cycle ModLoad only affects later increments.
  always_comb begin
    one_shot_mode = (OneShot == MODE_ONESHOT);
    term_value    = mod_q - WIDTH'(1);
    locked        = one_shot_mode && Done;
    // >= rather than == so a modulus shrunk below Count still terminates.
    terminal      = Increment && (Count >= term_value);
    pulse_next    = terminal && !locked;
    overrun_hit   = Increment && locked;
    count_next    = Count;
    if (Increment && !locked) begin
      if (!terminal) begin
        count_next = Count + WIDTH'(1);
      end else if (!one_shot_mode) begin
        count_next = '0;
      end
    end
  end

  // Registered count, flags and modulus; Clear wins over Increment, ModLoad is independent.
  always_ff @(posedge SystemClock or negedge ResetCounter) begin
    if (!ResetCounter) begin
      mod_q     <= WIDTH'(DEFAULT_MOD);
      Count     <= '0;
      TermPulse <= 1'b0;
      Done      <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      if (ModLoad) begin
        mod_q <= ModValue;
      end
      if (Clear) begin
        Count     <= '0;
        TermPulse <= 1'b0;
        Done      <= 1'b0;
        Overrun   <= 1'b0;
      end else begin
        Count     <= count_next;
        TermPulse <= pulse_next;
        if (pulse_next) begin
          Done <= 1'b1;
        end
        if (overrun_hit) begin
          Overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_modn_counter.sv
// Directed bench for modn_counter: driver pushes the expected post-edge state
// into a queue, a negedge monitor pops and compares.
module tb_modn_counter;

  localparam int W = 7;  // {count[3:0], term_pulse, done, overrun}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  modn_counter_if #(.WIDTH(4)) bus ();

  modn_counter #(.WIDTH(4), .DEFAULT_MOD(10)) dut (
    .SystemClock  (clk),
    .ResetCounter (rst_n),
    .Increment    (bus.increment),
    .Clear        (bus.clear),
    .ModLoad      (bus.mod_load),
    .ModValue     (bus.mod_value),
    .OneShot      (bus.one_shot),
    .Count        (bus.count),
    .TermPulse    (bus.term_pulse),
    .Done         (bus.done),
    .Overrun      (bus.overrun)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks   = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got count=%0d term=%0b done=%0b ovr=%0b, want count=%0d term=%0b done=%0b ovr=%0b",
               name, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [W-1:0] outputs_now();
    return {bus.count, bus.term_pulse, bus.done, bus.overrun};
  endfunction

  // Monitor: one expected entry per checked edge, compared on the following negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), outputs_now(), exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic idle_inputs();
    bus.increment = 1'b0;
    bus.clear     = 1'b0;
    bus.mod_load  = 1'b0;
    bus.mod_value = 4'd0;
    bus.one_shot  = 1'b0;
  endtask

  task automatic step(input string name, input logic inc, input logic clr, input logic ld,
                      input logic [3:0] val, input logic os,
                      input logic [3:0] ec, input logic et, input logic ed, input logic eo);
    @(negedge clk);
    bus.increment = inc;
    bus.clear     = clr;
    bus.mod_load  = ld;
    bus.mod_value = val;
    bus.one_shot  = os;
    @(posedge clk);
    exp_q.push_back({ec, et, ed, eo});
    name_q.push_back(name);
    #1;
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_state", outputs_now(), 7'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap mode, default modulus 10: 25 increments.
    for (int i = 1; i <= 25; i++) begin
      step("wrap_default", 1, 0, 0, 4'd0, 0, 4'(i % 10), (i % 10) == 0, i >= 10, 0);
    end
    step("clear_after_wrap", 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0);

    // One-shot, modulus 3: Count 1,2,2,2,2; pulse at 3, overrun from 4.
    step("load3", 0, 0, 1, 4'd3, 1, 4'd0, 0, 0, 0);
    step("os_inc1", 1, 0, 0, 4'd0, 1, 4'd1, 0, 0, 0);
    step("os_inc2", 1, 0, 0, 4'd0, 1, 4'd2, 0, 0, 0);
    step("os_inc3", 1, 0, 0, 4'd0, 1, 4'd2, 1, 1, 0);
    step("os_inc4", 1, 0, 0, 4'd0, 1, 4'd2, 0, 1, 1);
    step("os_inc5", 1, 0, 0, 4'd0, 1, 4'd2, 0, 1, 1);
    step("os_clear", 0, 1, 0, 4'd0, 1, 4'd0, 0, 0, 0);

    // Gapped increments with modulus 4.
    step("load4", 0, 0, 1, 4'd4, 0, 4'd0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step("gap_inc", 1, 0, 0, 4'd0, 0, 4'(k % 4), k == 4, k == 4, 0);
      for (int g = 0; g < 3; g++) begin
        step("gap_idle", 0, 0, 0, 4'd0, 0, 4'(k % 4), 0, k == 4, 0);
      end
    end
    step("gap_clear", 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0);

    // Shrink modulus below Count: 7 >= T=4 terminates.
    step("load10", 0, 0, 1, 4'd10, 0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      step("to7", 1, 0, 0, 4'd0, 0, 4'(i), 0, 0, 0);
    end
    step("load5_hold", 0, 0, 1, 4'd5, 0, 4'd7, 0, 0, 0);
    step("shrunk_term", 1, 0, 0, 4'd0, 0, 4'd0, 1, 1, 0);

    // Clear + ModLoad together, modulus 0 means 16.
    step("clear_load0", 0, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      step("mod16", 1, 0, 0, 4'd0, 0, 4'(i % 16), i == 16, i == 16, 0);
    end

    // ModLoad with Increment: judged against old T=15, new T=1 next time.
    step("clear2", 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0);
    step("pre_inc1", 1, 0, 0, 4'd0, 0, 4'd1, 0, 0, 0);
    step("pre_inc2", 1, 0, 0, 4'd0, 0, 4'd2, 0, 0, 0);
    step("load2_inc_oldT", 1, 0, 1, 4'd2, 0, 4'd3, 0, 0, 0);
    step("inc_newT", 1, 0, 0, 4'd0, 0, 4'd0, 1, 1, 0);

    // Modulus 1: terminal on every increment, Count stays 0.
    step("clear_load1", 0, 1, 1, 4'd1, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("mod1", 1, 0, 0, 4'd0, 0, 4'd0, 1, 1, 0);
    end

    // Clear beats Increment at Count=9.
    step("clear_load10", 0, 1, 1, 4'd10, 0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step("to9", 1, 0, 0, 4'd0, 0, 4'(i), 0, 0, 0);
    end
    step("clear_vs_inc", 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0);

    // Mode switch after wrap Done: one-shot with Done=1 locks the count.
    step("load3_b", 0, 0, 1, 4'd3, 0, 4'd0, 0, 0, 0);
    step("sw_inc1", 1, 0, 0, 4'd0, 0, 4'd1, 0, 0, 0);
    step("sw_inc2", 1, 0, 0, 4'd0, 0, 4'd2, 0, 0, 0);
    step("sw_wrap", 1, 0, 0, 4'd0, 0, 4'd0, 1, 1, 0);
    step("sw_locked", 1, 0, 0, 4'd0, 1, 4'd0, 0, 1, 1);

    // Async reset mid-count at Count=6, then modulus back to 10.
    step("clear_load7", 0, 1, 1, 4'd7, 0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step("to6", 1, 0, 0, 4'd0, 0, 4'(i), 0, 0, 0);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outputs_now(), 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step("post_reset_mod10", 1, 0, 0, 4'd0, 0, 4'(i % 10), i == 10, i == 10, 0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
